// File: rtl/counter_ctrl.sv
// Front-panel control for the loadable counter: synchronises and debounces the
// run/step/load buttons and switches, then issues registered active-low count
// enable and load strobes plus a programmable-rate free-running mode.
module counter_ctrl #(
    parameter int unsigned DivWidth  = 24,
    parameter int unsigned DbCycles  = 16,
    parameter int unsigned LoadWidth = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_run_btn,
    input  logic                 i_step_btn,
    input  logic                 i_load_btn,
    input  logic [LoadWidth-1:0] i_switches,
    input  logic [DivWidth-1:0]  i_div,
    output logic                 o_cnt_enable_n,
    output logic                 o_ld_enable_n,
    output logic [LoadWidth-1:0] o_load,
    output logic                 o_running
);

    localparam int unsigned     DbW    = $clog2(DbCycles);
    localparam logic [DbW-1:0]  DbLast = DbW'(DbCycles - 1);

    // Button bit positions
    localparam int unsigned BtnRun  = 0;
    localparam int unsigned BtnStep = 1;
    localparam int unsigned BtnLoad = 2;

    typedef enum logic [1:0] {
        StPause,
        StRun,
        StLoadP,
        StLoadR
    } state_e;

    logic [2:0]            btn_raw;
    logic [2:0]            btn_meta_q, btn_sync_q;
    logic [LoadWidth-1:0]  sw_meta_q, sw_sync_q;
    logic [2:0]            db_q, db_d, db_prev_q;
    logic [2:0][DbW-1:0]   db_cnt_q, db_cnt_d;
    logic [2:0]            ev;

    state_e                state_q, state_d;
    logic [DivWidth-1:0]   div_q, div_d;
    logic                  cnt_en_n_q, cnt_en_n_d;
    logic                  ld_en_n_q, ld_en_n_d;
    logic [LoadWidth-1:0]  load_q, load_d;
    logic                  running_q, running_d;

    assign btn_raw = {i_load_btn, i_step_btn, i_run_btn};

    // Two-flop synchronisers for buttons and switches
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            btn_meta_q <= '0;
            btn_sync_q <= '0;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
        end else begin
            btn_meta_q <= btn_raw;
            btn_sync_q <= btn_meta_q;
            sw_meta_q  <= i_switches;
            sw_sync_q  <= sw_meta_q;
        end
    end

    // Per-button debounce: count consecutive disagreeing samples, flip on the last one
    always_comb begin
        db_d     = db_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < 3; i++) begin
            if (btn_sync_q[i] == db_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DbLast) begin
                db_d[i]     = ~db_q[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
            end
        end
    end

    // Debounce state and previous value for edge detection
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            db_q      <= '0;
            db_prev_q <= '0;
            db_cnt_q  <= '0;
        end else begin
            db_q      <= db_d;
            db_prev_q <= db_q;
            db_cnt_q  <= db_cnt_d;
        end
    end

    // Press events are single-cycle rising edges of the debounced state
    assign ev = db_q & ~db_prev_q;

    // Control FSM: next state, divider and strobes; priority load > run > step
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        cnt_en_n_d = 1'b1;
        ld_en_n_d  = 1'b1;
        load_d     = load_q;
        running_d  = running_q;
        unique case (state_q)
            StPause: begin
                if (ev[BtnLoad]) begin
                    load_d    = sw_sync_q;
                    ld_en_n_d = 1'b0;
                    state_d   = StLoadP;
                end else if (ev[BtnRun]) begin
                    state_d   = StRun;
                    running_d = 1'b1;
                    div_d     = '0;
                end else if (ev[BtnStep]) begin
                    cnt_en_n_d = 1'b0;
                end
            end
            StRun: begin
                if (ev[BtnLoad]) begin
                    load_d    = sw_sync_q;
                    ld_en_n_d = 1'b0;
                    div_d     = '0;
                    state_d   = StLoadR;
                end else if (ev[BtnRun]) begin
                    state_d   = StPause;
                    running_d = 1'b0;
                    div_d     = '0;
                end else if (div_q >= i_div) begin
                    // >= so a lowered i_div still fires on the next edge
                    cnt_en_n_d = 1'b0;
                    div_d      = '0;
                end else begin
                    div_d = div_q + DivWidth'(1);
                end
            end
            StLoadP: begin
                div_d   = '0;
                state_d = StPause;
            end
            StLoadR: begin
                div_d   = '0;
                state_d = StRun;
            end
            default: begin
                state_d = StPause;
            end
        endcase
    end

    // FSM and registered outputs
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= StPause;
            div_q      <= '0;
            cnt_en_n_q <= 1'b1;
            ld_en_n_q  <= 1'b1;
            load_q     <= '0;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            cnt_en_n_q <= cnt_en_n_d;
            ld_en_n_q  <= ld_en_n_d;
            load_q     <= load_d;
            running_q  <= running_d;
        end
    end

    assign o_cnt_enable_n = cnt_en_n_q;
    assign o_ld_enable_n  = ld_en_n_q;
    assign o_load         = load_q;
    assign o_running      = running_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed self-checking bench for counter_ctrl (db_cycles=4, div_width=8).
module tb_counter_ctrl;

    logic       clk;
    logic       i_reset_n;
    logic       i_run_btn, i_step_btn, i_load_btn;
    logic [3:0] i_switches;
    logic [7:0] i_div;
    logic       o_cnt_enable_n, o_ld_enable_n, o_running;
    logic [3:0] o_load;

    int checks = 0;
    int errors = 0;

    counter_ctrl #(
        .DivWidth (8),
        .DbCycles (4),
        .LoadWidth(4)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (i_reset_n),
        .i_run_btn     (i_run_btn),
        .i_step_btn    (i_step_btn),
        .i_load_btn    (i_load_btn),
        .i_switches    (i_switches),
        .i_div         (i_div),
        .o_cnt_enable_n(o_cnt_enable_n),
        .o_ld_enable_n (o_ld_enable_n),
        .o_load        (o_load),
        .o_running     (o_running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Land 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold a button 10 cycles then release for 10 (0 run, 1 step, 2 load)
    task automatic press(input int which);
        case (which)
            0: i_run_btn = 1'b1;
            1: i_step_btn = 1'b1;
            default: i_load_btn = 1'b1;
        endcase
        repeat (10) step();
        i_run_btn = 1'b0; i_step_btn = 1'b0; i_load_btn = 1'b0;
        repeat (10) step();
    endtask

    task automatic test_reset();
        int n_cnt, n_ld, n_run;
        i_reset_n = 1'b0;
        i_run_btn = 0; i_step_btn = 0; i_load_btn = 0;
        i_switches = 4'h0; i_div = 8'd255;
        repeat (3) step();
        checks++; if (o_cnt_enable_n !== 1'b1) begin errors++; $display("FAIL reset_cnt_en: got %b expected 1", o_cnt_enable_n); end
        checks++; if (o_ld_enable_n !== 1'b1) begin errors++; $display("FAIL reset_ld_en: got %b expected 1", o_ld_enable_n); end
        checks++; if (o_load !== 4'h0) begin errors++; $display("FAIL reset_load: got %h expected 0", o_load); end
        checks++; if (o_running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b expected 0", o_running); end
        i_reset_n = 1'b1;
        n_cnt = 0; n_ld = 0; n_run = 0;
        for (int k = 0; k < 50; k++) begin
            step();
            if (!o_cnt_enable_n) n_cnt++;
            if (!o_ld_enable_n) n_ld++;
            if (o_running) n_run++;
        end
        checks++; if (n_cnt != 0) begin errors++; $display("FAIL idle_cnt_pulses: got %0d expected 0", n_cnt); end
        checks++; if (n_ld != 0) begin errors++; $display("FAIL idle_ld_pulses: got %0d expected 0", n_ld); end
        checks++; if (n_run != 0) begin errors++; $display("FAIL idle_running: got %0d expected 0", n_run); end
    endtask

    task automatic test_load();
        int first_ld, n_ld, n_cnt;
        first_ld = -1; n_ld = 0; n_cnt = 0;
        i_switches = 4'hA;
        i_load_btn = 1'b1;
        for (int k = 0; k < 106; k++) begin
            step();
            if (k == 5) begin
                checks++; if (o_load !== 4'h0) begin errors++; $display("FAIL load_before_strobe: got %h expected 0", o_load); end
            end
            if (!o_ld_enable_n) begin
                n_ld++;
                if (first_ld < 0) first_ld = k;
            end
            if (!o_cnt_enable_n) n_cnt++;
        end
        checks++; if (first_ld != 6) begin errors++; $display("FAIL load_latency: got %0d expected 6", first_ld); end
        checks++; if (n_ld != 1) begin errors++; $display("FAIL load_single_strobe: got %0d expected 1", n_ld); end
        checks++; if (n_cnt != 0) begin errors++; $display("FAIL load_no_cnt: got %0d expected 0", n_cnt); end
        checks++; if (o_load !== 4'hA) begin errors++; $display("FAIL load_value: got %h expected a", o_load); end
        i_load_btn = 1'b0;
        i_switches = 4'h3;
        n_ld = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (!o_ld_enable_n) n_ld++;
        end
        checks++; if (n_ld != 0) begin errors++; $display("FAIL load_release: got %0d expected 0", n_ld); end
        checks++; if (o_load !== 4'hA) begin errors++; $display("FAIL load_held: got %h expected a", o_load); end
    endtask

    task automatic test_bounce();
        int rises, n_cnt;
        logic prev;
        rises = 0; n_cnt = 0; prev = o_running;
        for (int i = 0; i < 42; i++) begin
            i_run_btn = ((i / 3) % 2 == 0);
            step();
            if (o_running && !prev) rises++;
            if (!o_cnt_enable_n) n_cnt++;
            prev = o_running;
        end
        checks++; if (rises != 0) begin errors++; $display("FAIL bounce_glitch_event: got %0d expected 0", rises); end
        i_run_btn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (o_running && !prev) rises++;
            if (!o_cnt_enable_n) n_cnt++;
            prev = o_running;
        end
        i_run_btn = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (o_running !== prev) rises++;
            if (!o_cnt_enable_n) n_cnt++;
            prev = o_running;
        end
        checks++; if (rises != 1) begin errors++; $display("FAIL bounce_events: got %0d expected 1", rises); end
        checks++; if (o_running !== 1'b1) begin errors++; $display("FAIL bounce_running: got %b expected 1", o_running); end
        checks++; if (n_cnt != 0) begin errors++; $display("FAIL bounce_no_tick: got %0d expected 0", n_cnt); end
        press(0);
        checks++; if (o_running !== 1'b0) begin errors++; $display("FAIL bounce_back_to_pause: got %b expected 0", o_running); end
    endtask

    task automatic test_run_rate();
        int kr, first, last, gap_err, npulses, n_high, fall_k, low_before, low_after;
        logic prev;
        kr = -1; first = -1; last = -1; gap_err = 0; npulses = 0;
        prev = o_running;
        i_div = 8'd3;
        i_run_btn = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (k == 10) i_run_btn = 1'b0;
            step();
            if (o_running && !prev) kr = k;
            prev = o_running;
            if (!o_cnt_enable_n) begin
                if (first < 0) first = k;
                else if (k - last != 4) gap_err++;
                last = k;
                npulses++;
            end
        end
        checks++; if (kr != 6) begin errors++; $display("FAIL run_latency: got %0d expected 6", kr); end
        checks++; if (first - kr != 4) begin errors++; $display("FAIL run_first_tick: got %0d expected 4", first - kr); end
        checks++; if (gap_err != 0) begin errors++; $display("FAIL run_period: got %0d bad gaps expected 0", gap_err); end
        checks++; if (npulses != 8) begin errors++; $display("FAIL run_pulse_count: got %0d expected 8", npulses); end
        i_div = 8'd0;
        n_high = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (o_cnt_enable_n) n_high++;
        end
        checks++; if (n_high != 0) begin errors++; $display("FAIL run_div0_held_low: got %0d high cycles expected 0", n_high); end
        fall_k = -1; low_before = 0; low_after = 0; prev = o_running;
        i_run_btn = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            if (!o_running && prev) fall_k = k;
            prev = o_running;
            if (!o_cnt_enable_n) begin
                if (k < 6) low_before++;
                else low_after++;
            end
        end
        i_run_btn = 1'b0;
        repeat (12) step();
        checks++; if (fall_k != 6) begin errors++; $display("FAIL run_stop_latency: got %0d expected 6", fall_k); end
        checks++; if (low_before != 6) begin errors++; $display("FAIL run_stop_before: got %0d expected 6", low_before); end
        checks++; if (low_after != 0) begin errors++; $display("FAIL run_stop_enable_high: got %0d expected 0", low_after); end
        checks++; if (o_running !== 1'b0) begin errors++; $display("FAIL run_stopped: got %b expected 0", o_running); end
    endtask

    task automatic test_async_reset();
        int n_cnt, n_ld;
        i_div = 8'd0;
        press(0);
        checks++; if (o_cnt_enable_n !== 1'b0) begin errors++; $display("FAIL areset_pre_pulse: got %b expected 0", o_cnt_enable_n); end
        #3;
        i_reset_n = 1'b0;
        #1;
        checks++; if (o_cnt_enable_n !== 1'b1) begin errors++; $display("FAIL areset_cnt_en: got %b expected 1", o_cnt_enable_n); end
        checks++; if (o_running !== 1'b0) begin errors++; $display("FAIL areset_running: got %b expected 0", o_running); end
        checks++; if (o_load !== 4'h0) begin errors++; $display("FAIL areset_load: got %h expected 0", o_load); end
        checks++; if (o_ld_enable_n !== 1'b1) begin errors++; $display("FAIL areset_ld_en: got %b expected 1", o_ld_enable_n); end
        repeat (2) step();
        i_reset_n = 1'b1;
        n_cnt = 0; n_ld = 0;
        for (int k = 0; k < 50; k++) begin
            step();
            if (!o_cnt_enable_n) n_cnt++;
            if (!o_ld_enable_n) n_ld++;
        end
        checks++; if (n_cnt + n_ld != 0) begin errors++; $display("FAIL areset_quiet: got %0d strobes expected 0", n_cnt + n_ld); end
    endtask

    task automatic test_step();
        int lows, falls;
        logic prev;
        i_div = 8'd3;
        lows = 0; falls = 0; prev = o_cnt_enable_n;
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 20; k++) begin
                i_step_btn = (k < 10);
                step();
                if (!o_cnt_enable_n) lows++;
                if (!o_cnt_enable_n && prev) falls++;
                prev = o_cnt_enable_n;
            end
        end
        i_step_btn = 1'b0;
        checks++; if (lows != 3) begin errors++; $display("FAIL step_low_cycles: got %0d expected 3", lows); end
        checks++; if (falls != 3) begin errors++; $display("FAIL step_pulses: got %0d expected 3", falls); end
        i_div = 8'd255;
        press(0);
        checks++; if (o_running !== 1'b1) begin errors++; $display("FAIL step_enter_run: got %b expected 1", o_running); end
        lows = 0;
        i_step_btn = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (k == 10) i_step_btn = 1'b0;
            step();
            if (!o_cnt_enable_n) lows++;
        end
        checks++; if (lows != 0) begin errors++; $display("FAIL step_ignored_in_run: got %0d expected 0", lows); end
        press(0);
    endtask

    task automatic test_simultaneous();
        int n_ld, n_run, n_cnt, ld_k, next_k, near, overlap;
        n_ld = 0; n_run = 0; n_cnt = 0;
        i_switches = 4'h5;
        i_load_btn = 1'b1; i_run_btn = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (k == 10) begin i_load_btn = 1'b0; i_run_btn = 1'b0; end
            step();
            if (!o_ld_enable_n) n_ld++;
            if (o_running) n_run++;
            if (!o_cnt_enable_n) n_cnt++;
        end
        checks++; if (n_ld != 1) begin errors++; $display("FAIL simul_ld_strobes: got %0d expected 1", n_ld); end
        checks++; if (n_run != 0) begin errors++; $display("FAIL simul_running: got %0d cycles expected 0", n_run); end
        checks++; if (o_load !== 4'h5) begin errors++; $display("FAIL simul_load: got %h expected 5", o_load); end
        checks++; if (n_cnt != 0) begin errors++; $display("FAIL simul_no_cnt: got %0d expected 0", n_cnt); end
        i_div = 8'd5;
        press(0);
        i_switches = 4'h9;
        ld_k = -1; next_k = -1; near = 0; overlap = 0; n_ld = 0;
        i_load_btn = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (k == 10) i_load_btn = 1'b0;
            step();
            if (!o_ld_enable_n) begin
                n_ld++;
                if (ld_k < 0) ld_k = k;
            end
            if (!o_ld_enable_n && !o_cnt_enable_n) overlap++;
            if (!o_cnt_enable_n && ld_k >= 0) begin
                if (k == ld_k || k == ld_k + 1) near++;
                if (k > ld_k && next_k < 0) next_k = k;
            end
        end
        checks++; if (n_ld != 1) begin errors++; $display("FAIL runload_strobes: got %0d expected 1", n_ld); end
        checks++; if (overlap != 0) begin errors++; $display("FAIL runload_overlap: got %0d expected 0", overlap); end
        checks++; if (near != 0) begin errors++; $display("FAIL runload_no_enable: got %0d expected 0", near); end
        checks++; if (next_k - ld_k != 7) begin errors++; $display("FAIL runload_restart: got %0d expected 7", next_k - ld_k); end
        checks++; if (o_load !== 4'h9) begin errors++; $display("FAIL runload_value: got %h expected 9", o_load); end
        checks++; if (o_running !== 1'b1) begin errors++; $display("FAIL runload_running: got %b expected 1", o_running); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_bounce();
        test_run_rate();
        test_async_reset();
        test_step();
        test_simultaneous();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
